// File: rtl/up_counter_4bit_core.sv
// Purpose : free-running unsigned up-counter with terminal-count look-ahead,
//           a one-cycle wrap strobe and an optional saturating wrap counter.
// Latency : count/wrap/wrap_cnt registered (1 edge); tc is combinational from count.
// Backpressure: none -- no handshake, the counter advances on every edge out of reset.
//
// Ports:
//   clk      : rising-edge clock, sole domain
//   rst      : synchronous active-low reset (0 at an edge clears all state)
//   count    : current counter value, WIDTH bits
//   tc       : high while count is at its maximum (2^WIDTH-1)
//   wrap     : high for the one cycle after count rolls from max to 0
//   wrap_cnt : saturating number of wraps since reset
//
// Build option: define UP_COUNTER_WRAP_STATS_EN to build the wrap statistics
// register; without it wrap_cnt is a constant 0 and the port is kept so both
// builds share one interface.

module up_counter_4bit_core #(
    parameter int WIDTH      = 4,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  wrap,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
);

    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

    // tc doubles as the "rollover on this edge" indication: when count is at
    // max and reset is not asserted, the next edge wraps to 0.
    assign tc = (count == COUNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count + 1'b1;
            wrap  <= tc;
        end
    end

`ifdef UP_COUNTER_WRAP_STATS_EN
    localparam logic [WRAP_CNT_W-1:0] WRAP_CNT_MAX = {WRAP_CNT_W{1'b1}};

    // Counts the same edges on which wrap is set; holds at all-ones so a long
    // free run never reports a misleadingly small value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap_cnt <= '0;
        end else if (tc && (wrap_cnt != WRAP_CNT_MAX)) begin
            wrap_cnt <= wrap_cnt + 1'b1;
        end
    end
`else
    assign wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_up_counter_4bit_core.sv
// Purpose : scoreboard bench for up_counter_4bit_core (WIDTH=4, WRAP_CNT_W=2).
// Latency : expectations are queued one edge ahead and checked 1 unit after each edge.
// Backpressure: not applicable; the DUT presents a new output every cycle.

module tb_up_counter_4bit_core;

    localparam int W   = 4;
    localparam int WCW = 2;
    localparam int P   = 1 << W;          // counter period
    localparam int WSAT = (1 << WCW) - 1; // wrap_cnt saturation value

    typedef struct packed {
        logic [W-1:0]   c;
        logic           t;
        logic           w;
        logic [WCW-1:0] wc;
    } exp_t;

    logic           clk;
    logic           rst;
    logic [W-1:0]   count;
    logic           tc;
    logic           wrap;
    logic [WCW-1:0] wrap_cnt;

    up_counter_4bit_core #(.WIDTH(W), .WRAP_CNT_W(WCW)) dut (
        .clk      (clk),
        .rst      (rst),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .wrap_cnt (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: n = edges taken since the last reset edge.
    // count = n mod P, a wrap happened on this edge iff n is a positive
    // multiple of P, and the number of wraps since reset is n / P.
    int n = 0;
    bit prev_rst = 1'b0;

    function automatic exp_t predict(input int edges);
        exp_t e;
        int wraps;
        e.c = W'(edges % P);
        e.t = ((edges % P) == P - 1);
        e.w = (edges > 0) && ((edges % P) == 0);
`ifdef UP_COUNTER_WRAP_STATS_EN
        wraps = edges / P;
        if (wraps > WSAT) wraps = WSAT;
`else
        wraps = 0;
`endif
        e.wc = WCW'(wraps);
        return e;
    endfunction

    // Set rst for the coming edge and queue what the DUT must show after it.
    function automatic void model_edge(input bit r);
        if (!r) n = 0;
        else    n = n + 1;
        exp_q.push_back(predict(n));
    endfunction

    // Drive rst 2 units after an edge (i.e. mid-cycle). When reset is newly
    // asserted, confirm count has not reacted before the next edge.
    task automatic drive(input bit r);
        @(posedge clk);
        #2;
        rst = r;
        if (!r && prev_rst) begin
            #1;
            checks++;
            if (count !== W'(n % P)) begin
                errors++;
                $display("FAIL midcycle_hold: count=%0d expected=%0d", count, n % P);
            end
        end
        prev_rst = r;
        model_edge(r);
    endtask

    // Monitor: one queued expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL queue_underflow: no expectation at time %0t", $time);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (count !== e.c) begin
                    errors++;
                    $display("FAIL count: got=%0d expected=%0d t=%0t", count, e.c, $time);
                end
                checks++;
                if (tc !== e.t) begin
                    errors++;
                    $display("FAIL tc: got=%b expected=%b count_exp=%0d t=%0t", tc, e.t, e.c, $time);
                end
                checks++;
                if (wrap !== e.w) begin
                    errors++;
                    $display("FAIL wrap: got=%b expected=%b count_exp=%0d t=%0t", wrap, e.w, e.c, $time);
                end
                checks++;
                if (wrap_cnt !== e.wc) begin
                    errors++;
                    $display("FAIL wrap_cnt: got=%0d expected=%0d t=%0t", wrap_cnt, e.wc, $time);
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst = 1'b0;
        prev_rst = 1'b0;
        model_edge(1'b0);                       // first edge, reset held
        drive(1'b0);                            // second reset edge
        for (int i = 0; i < 17; i++) drive(1'b1); // 1..15, wrap to 0, then 1
        drive(1'b1);                            // count = 2
        drive(1'b0);                            // mid-cycle reset from 2 -> 0
        drive(1'b0);                            // hold one more cycle
        for (int i = 0; i < 15; i++) drive(1'b1); // 1..15
        drive(1'b0);                            // reset at terminal count
        for (int i = 0; i < 5 * P + 3; i++) drive(1'b1); // statistics run
        for (int i = 0; i < 400; i++) drive(($urandom_range(0, 19) != 0));
        for (int i = 0; i < 2 * P; i++) drive(1'b1);
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
